// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder.
// Op codes and a constant-foldable ceil(log2) helper.
package ksa_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: combine each G/P pair
// with the pair SPAN positions below it.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] go,
  output logic [WIDTH-1:0] po
);

  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    if (j >= SPAN) begin : g_comb
      assign go[j] = g[j] | (p[j] & g[j-SPAN]);
      assign po[j] = p[j] & p[j-SPAN];
    end else begin : g_pass
      assign go[j] = g[j];
      assign po[j] = p[j];
    end
  end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready
// handshakes, carry out and signed overflow.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int LEVELS = clog2(WIDTH);
  // index 0 holds the carry-in as a generate bit (position -1)
  localparam int N = WIDTH + 1;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] hp0;
  logic             cin0;
  logic [N-1:0]     g0;
  logic [N-1:0]     p0;

  assign bx   = B ^ {WIDTH{Sub}};
  assign cin0 = (Sub == SUB) ? 1'b1 : Cin;
  assign hp0  = A ^ bx;
  assign g0   = {A & bx, cin0};
  assign p0   = {hp0, 1'b0};

  logic [LEVELS:0][N-1:0]     rg;
  logic [LEVELS:0][N-1:0]     rp;
  logic [LEVELS:0][WIDTH-1:0] rh;
  logic [LEVELS:0]            rv;

  logic [LEVELS-1:0][N-1:0] ng;
  logic [LEVELS-1:0][N-1:0] np;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    ksa_prefix_level #(
      .WIDTH (N),
      .SPAN  (1 << l)
    ) u_lvl (
      .g  (rg[l]),
      .p  (rp[l]),
      .go (ng[l]),
      .po (np[l])
    );
  end

  // The top prefix spans WIDTH positions; the last
  // combine with the carry-in slot completes every carry.
  logic [N-1:0]     gf;
  logic [WIDTH-1:0] fsum;
  logic             fc;
  logic             fo;

  assign gf   = rg[LEVELS]
              | (rp[LEVELS] & {N{rg[LEVELS][0]}});
  assign fsum = rh[LEVELS] ^ gf[WIDTH-1:0];
  assign fc   = gf[WIDTH];
  assign fo   = gf[WIDTH-1] ^ gf[WIDTH];

  // Whole pipeline advances together or holds on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      rv        <= '0;
      rg        <= '0;
      rp        <= '0;
      rh        <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else if (adv) begin
      rv[0] <= in_valid;
      rg[0] <= g0;
      rp[0] <= p0;
      rh[0] <= hp0;
      for (int l = 0; l < LEVELS; l++) begin
        rv[l+1] <= rv[l];
        rg[l+1] <= ng[l];
        rp[l+1] <= np[l];
        rh[l+1] <= rh[l];
      end
      out_valid <= rv[LEVELS];
      Sum       <= fsum;
      Cout      <= fc;
      Ovf       <= fo;
    end
  end

endmodule
